// File: rtl/wb_scratch_if.sv
// Pipelined Wishbone request/response bundle between the bridge (master) and the scratch slave.
interface wb_scratch_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        stall;
  logic        err;
  logic [31:0] rdata;

  modport master (output cyc, stb, we, addr, wdata, input  ack, stall, err, rdata);
  modport slave  (input  cyc, stb, we, addr, wdata, output ack, stall, err, rdata);
endinterface

// File: rtl/wb_scratch_slave.sv
// Wishbone scratch slave: 2**AW x 32 RAM plus ID/CTRL/DOORBELL/INT_STATUS registers.
// Define WB_SCRATCH_RDPIPE_EN to add a second response stage (2-cycle latency on every access).
module wb_scratch_slave #(
    parameter int          AW       = 10,
    parameter logic [31:0] ID_VALUE = 32'h5A2B0001
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_evt,
    output logic         o_int,
    output logic [1:0]   o_dbg_resp,
    wb_scratch_if.slave  wb
);

    // Handshake: a request is taken whenever cyc & stb (stall is always 0); exactly one of ack/err
    // is pulsed per request, in order, and only while cyc stays high.
    typedef enum logic [1:0] {IDLE = 2'd0, RESP_ACK = 2'd1, RESP_ERR = 2'd2} resp_e;

    localparam logic [31:0] RAM_WORDS = 32'(1) << AW;

    logic [31:0] mem [2**AW];

    logic        accept;
    logic        is_ram;
    logic        is_reg;
    logic        bad;
    logic [31:0] off;
    logic [31:0] reg_val;
    logic [AW-1:0] ram_idx;

    logic [1:0]  ctrl_q,   ctrl_d;
    logic [1:0]  status_q, status_d;
    logic [15:0] count_q,  count_d;
    logic        int_q,    int_d;
    resp_e       st1_q,    st1_d;
    logic        rd1_q,    rd1_d;
    logic [31:0] data1_q,  data1_d;

    resp_e       st_out;
    logic        rd_out;
    logic [31:0] data_out;

    always_comb begin
        accept  = wb.cyc & wb.stb;
        off     = wb.addr - RAM_WORDS;
        is_ram  = (wb.addr < RAM_WORDS);
        is_reg  = (off < 32'd4);
        ram_idx = wb.addr[AW-1:0];
        bad     = !is_ram && (!is_reg || (off[1:0] == 2'd0 && wb.we));

        case (off[1:0])
            2'd0:    reg_val = ID_VALUE;
            2'd1:    reg_val = {30'h0, ctrl_q};
            2'd2:    reg_val = {16'h0, count_q};
            default: reg_val = {30'h0, status_q};
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        status_d = status_q;
        count_d  = count_q;
        if (accept && wb.we && is_reg) begin
            case (off[1:0])
                2'd1: ctrl_d = wb.wdata[1:0];
                2'd2: begin
                    status_d[0] = 1'b1;
                    count_d     = count_q + 16'd1;
                end
                2'd3: status_d = status_q & ~wb.wdata[1:0];
                default: ;
            endcase
        end
        // External event is applied after W1C so a coincident clear loses.
        if (i_evt) status_d[1] = 1'b1;
        int_d = |(status_q & ctrl_q);
    end

    always_comb begin
        st1_d   = IDLE;
        rd1_d   = 1'b0;
        data1_d = data1_q;
        if (accept) begin
            st1_d = bad ? RESP_ERR : RESP_ACK;
            rd1_d = !wb.we && !bad;
            if (!wb.we && !bad) data1_d = is_ram ? mem[ram_idx] : reg_val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept && wb.we && is_ram) mem[ram_idx] <= wb.wdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl_q   <= 2'b0;
            status_q <= 2'b0;
            count_q  <= 16'h0;
            int_q    <= 1'b0;
            st1_q    <= IDLE;
            rd1_q    <= 1'b0;
            data1_q  <= 32'h0;
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            count_q  <= count_d;
            int_q    <= int_d;
            st1_q    <= st1_d;
            rd1_q    <= rd1_d;
            data1_q  <= data1_d;
        end
    end

`ifdef WB_SCRATCH_RDPIPE_EN
    resp_e       st2_q,   st2_d;
    logic        rd2_q,   rd2_d;
    logic [31:0] data2_q, data2_d;

    // Dropping cyc flushes the first stage before it can reach the output stage.
    always_comb begin
        st2_d   = wb.cyc ? st1_q : IDLE;
        rd2_d   = wb.cyc & rd1_q;
        data2_d = data2_q;
        if (wb.cyc && st1_q == RESP_ACK && rd1_q) data2_d = data1_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st2_q   <= IDLE;
            rd2_q   <= 1'b0;
            data2_q <= 32'h0;
        end else begin
            st2_q   <= st2_d;
            rd2_q   <= rd2_d;
            data2_q <= data2_d;
        end
    end

    assign st_out   = st2_q;
    assign rd_out   = rd2_q;
    assign data_out = data2_q;
`else
    assign st_out   = st1_q;
    assign rd_out   = rd1_q;
    assign data_out = data1_q;
`endif

    assign wb.ack     = (st_out == RESP_ACK) & wb.cyc;
    assign wb.err     = (st_out == RESP_ERR) & wb.cyc;
    assign wb.stall   = 1'b0;
    // Read data is held between reads; write and error response cycles drive zero.
    assign wb.rdata   = (st_out != IDLE && !rd_out) ? 32'h0 : data_out;
    assign o_int      = int_q;
    assign o_dbg_resp = st_out;

endmodule
